wrr_hold_arbiter: RTL and testbench



---
 rtl/wrr_pkg.sv | 22 ++
 rtl/wrr_hold_arbiter_if.sv | 38 +++
 rtl/wrr_hold_arbiter_rr_pick.sv | 29 ++
 rtl/wrr_hold_arbiter.sv | 112 +++++++++++
 tb/tb_wrr_hold_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/wrr_pkg.sv
// Shared types and defaults for the weighted
// round-robin hold arbiter.
package wrr_pkg;

  localparam int N_REQ   = 4;
  localparam int W_WIDTH = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef logic [W_WIDTH-1:0] weight_t;

  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/wrr_hold_arbiter_if.sv
// Request/grant and weight-programming
// signals between requesters and arbiter.
interface wrr_hold_arbiter_if #(
  parameter int N  = 4,
  parameter int WW = 4
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  request;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [WW-1:0] cfg_weight;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;

  modport master (
    output request,
    output cfg_we,
    output cfg_idx,
    output cfg_weight,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request,
    input  cfg_we,
    input  cfg_idx,
    input  cfg_weight,
    output grant,
    output grant_valid,
    output grant_id
  );

endinterface

// File: rtl/wrr_hold_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit
// of eligible scanning from ptr upward.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]                     eligible,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic                             found,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Scan from farthest to nearest so the
  // nearest eligible index is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (eligible[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wrr_hold_arbiter.sv
// Four-way weighted round-robin arbiter
// with registered one-hot grant bursts.
module wrr_hold_arbiter
  import wrr_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int WW = W_WIDTH
) (
  input logic               clk,
  input logic               rst,
  wrr_hold_arbiter_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state_q, state_d;
  logic [WW-1:0] credit_q, credit_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [WW-1:0] weight_q [N];
  logic [WW-1:0] weight_d [N];

  logic [N-1:0]  eligible;
  logic          found;
  logic [IW-1:0] pick;
  logic          load;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = bus.request[i] &&
                    (weight_q[i] != '0);
    end
  end

  // ptr_q always equals owner+1 while busy,
  // so one pointer serves both pick cases.
  rr_pick #(.N(N)) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (found),
    .idx      (pick)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    grant_d  = grant_q;
    weight_d = weight_q;
    load     = 1'b0;

    unique case (state_q)
      IDLE: load = found;
      BUSY: begin
        if (bus.request[id_q] &&
            credit_q > WW'(1)) begin
          credit_d = credit_q - WW'(1);
        end else if (found) begin
          load = 1'b1;
        end else begin
          state_d  = IDLE;
          grant_d  = '0;
          id_d     = '0;
          credit_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d       = BUSY;
      grant_d       = '0;
      grant_d[pick] = 1'b1;
      id_d          = pick;
      credit_d      = weight_q[pick];
      ptr_d         = IW'(wrap_inc(int'(pick), N));
    end

    // Arbitration above reads weight_q, so a
    // same-edge write only affects later picks.
    if (bus.cfg_we && int'(bus.cfg_idx) < N) begin
      weight_d[bus.cfg_idx] = bus.cfg_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      ptr_q    <= '0;
      id_q     <= '0;
      grant_q  <= '0;
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= WW'(1);
      end
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      grant_q  <= grant_d;
      weight_q <= weight_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_id    = id_q;

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// Directed bench for wrr_hold_arbiter with
// hand-computed grant sequences.
module tb_wrr_hold_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  wrr_hold_arbiter_if #(.N(4), .WW(4)) bus ();

  wrr_hold_arbiter #(.N(4), .WW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.request    = '0;
    bus.cfg_we     = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg(
    input int idx,
    input int w
  );
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = 2'(idx);
    bus.cfg_weight = 4'(w);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic chk_id(
    input string tag,
    input int    id
  );
    chk({tag, "_id"}, int'(bus.grant_id), id);
    chk({tag, "_gnt"}, int'(bus.grant), 1 << id);
  endtask

  int e1 [6] = '{1, 2, 1, 2, 1, 2};
  int e2 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int e5 [6] = '{0, 2, 3, 0, 2, 3};
  int e5b [6] = '{1, 1, 2, 3, 0, 1};

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.request    = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_weight = '0;
    tick();
    tick();
    chk("rst_gnt", int'(bus.grant), 0);
    chk("rst_vld", int'(bus.grant_valid), 0);
    chk("rst_id", int'(bus.grant_id), 0);

    // equal weights alternate with no gaps
    rst         = 1'b0;
    bus.request = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t1_%0d", i),
          int'(bus.grant), e1[i]);
      chk($sformatf("t1v_%0d", i),
          int'(bus.grant_valid), 1);
    end

    // w0=3, w1=1
    do_reset();
    cfg(0, 3);
    cfg(1, 1);
    bus.request = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_id($sformatf("t2_%0d", i), e2[i]);
    end

    // lone requester reloads without a gap
    do_reset();
    cfg(2, 2);
    bus.request = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_%0d", i),
          int'(bus.grant), 4'b0100);
    end

    // early release on request drop
    do_reset();
    cfg(0, 4);
    bus.request = 4'b0101;
    tick();
    chk_id("t4_a", 0);
    tick();
    chk_id("t4_b", 0);
    bus.request = 4'b0100;
    tick();
    chk_id("t4_c", 2);
    bus.request = 4'b0000;
    tick();
    chk("t4_gnt", int'(bus.grant), 0);
    chk("t4_vld", int'(bus.grant_valid), 0);
    chk("t4_id", int'(bus.grant_id), 0);

    // masked requester, then rejoin with w=2
    do_reset();
    cfg(1, 0);
    bus.request = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_id($sformatf("t5_%0d", i), e5[i]);
    end
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = 2'd1;
    bus.cfg_weight = 4'd2;
    tick();
    bus.cfg_we = 1'b0;
    chk_id("t5_wr", 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_id($sformatf("t5b_%0d", i), e5b[i]);
    end

    // reset mid-burst restores weight 1
    do_reset();
    cfg(3, 3);
    bus.request = 4'b1000;
    tick();
    chk("t6_a", int'(bus.grant), 4'b1000);
    tick();
    chk("t6_b", int'(bus.grant), 4'b1000);
    rst = 1'b1;
    tick();
    chk("t6_rg", int'(bus.grant), 0);
    chk("t6_rv", int'(bus.grant_valid), 0);
    chk("t6_ri", int'(bus.grant_id), 0);
    rst = 1'b0;
    tick();
    chk("t6_c", int'(bus.grant), 4'b1000);
    bus.request = 4'b1100;
    tick();
    chk("t6_d", int'(bus.grant), 4'b0100);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
